// File: rtl/lsu_seq.sv
// Load/store sequencer: one access at a time from the core's memory stage onto a
// single-ported data bus, with big-endian lane placement, alignment check and timeout.
module lsu_seq #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_fn4,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_mask,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    // state | meaning
    // IDLE  | ready for a request
    // BUS   | bus cycle outstanding, waiting for ack/err/timeout
    // RESP  | one-cycle response to the core
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        we_q, we_nx;
    logic [3:0]  fn4_q, fn4_nx;
    logic [1:0]  off_q, off_nx;

    logic        req_ready_nx, rsp_valid_nx, rsp_err_nx;
    logic [31:0] rsp_rdata_nx;
    logic        bus_req_nx, bus_we_nx;
    logic [31:0] bus_addr_nx, bus_wdata_nx;
    logic [3:0]  bus_mask_nx;

    logic        aligned;
    logic [3:0]  mask_c;
    logic [31:0] wdata_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Request decode: alignment, byte enables and lane-placed store data.
    always_comb begin
        aligned = 1'b1;
        mask_c  = 4'b1111;
        wdata_c = req_wdata;
        casez (req_fn4)
            4'b??00: begin
                mask_c  = 4'b1000 >> req_addr[1:0];
                wdata_c = {req_wdata[7:0], 24'b0} >> {req_addr[1:0], 3'b000};
            end
            4'b??01: begin
                aligned = ~req_addr[0];
                mask_c  = req_addr[1] ? 4'b0011 : 4'b1100;
                wdata_c = req_addr[1] ? {16'b0, req_wdata[15:0]} : {req_wdata[15:0], 16'b0};
            end
            default: aligned = (req_addr[1:0] == 2'b00);
        endcase
    end

    // Load formatting from the latched size/sign and byte offset.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus_rdata[31:24];
            2'd1:    ld_byte = bus_rdata[23:16];
            2'd2:    ld_byte = bus_rdata[15:8];
            default: ld_byte = bus_rdata[7:0];
        endcase
        ld_half = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        casez (fn4_q)
            4'b??00: ld_data = {{24{fn4_q[3] & ld_byte[7]}}, ld_byte};
            4'b??01: ld_data = {{16{fn4_q[3] & ld_half[15]}}, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        we_nx        = we_q;
        fn4_nx       = fn4_q;
        off_nx       = off_q;
        req_ready_nx = req_ready;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = 1'b0;
        rsp_rdata_nx = rsp_rdata;
        bus_req_nx   = bus_req;
        bus_we_nx    = bus_we;
        bus_addr_nx  = bus_addr;
        bus_wdata_nx = bus_wdata;
        bus_mask_nx  = bus_mask;
        case (state)
            IDLE: begin
                req_ready_nx = 1'b1;
                if (req_valid) begin
                    req_ready_nx = 1'b0;
                    if (aligned) begin
                        we_nx        = req_we;
                        fn4_nx       = req_fn4;
                        off_nx       = req_addr[1:0];
                        cnt_nx       = 8'd0;
                        bus_req_nx   = 1'b1;
                        bus_we_nx    = req_we;
                        bus_addr_nx  = {req_addr[31:2], 2'b00};
                        bus_wdata_nx = req_we ? wdata_c : 32'd0;
                        bus_mask_nx  = mask_c;
                        state_nx     = BUS;
                    end else begin
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b1;
                        rsp_rdata_nx = 32'd0;
                        state_nx     = RESP;
                    end
                end
            end
            BUS: begin
                req_ready_nx = 1'b0;
                cnt_nx       = cnt + 8'd1;
                if (bus_err || bus_ack || cnt == CNT_LAST) begin
                    bus_req_nx   = 1'b0;
                    rsp_valid_nx = 1'b1;
                    state_nx     = RESP;
                    if (!bus_err && bus_ack) begin
                        rsp_rdata_nx = we_q ? 32'd0 : ld_data;
                    end else begin
                        rsp_err_nx   = 1'b1;
                        rsp_rdata_nx = 32'd0;
                    end
                end
            end
            default: begin
                req_ready_nx = 1'b1;
                cnt_nx       = 8'd0;
                state_nx     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            we_q      <= 1'b0;
            fn4_q     <= 4'd0;
            off_q     <= 2'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_mask  <= 4'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            we_q      <= we_nx;
            fn4_q     <= fn4_nx;
            off_q     <= off_nx;
            req_ready <= req_ready_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_err   <= rsp_err_nx;
            rsp_rdata <= rsp_rdata_nx;
            bus_req   <= bus_req_nx;
            bus_we    <= bus_we_nx;
            bus_addr  <= bus_addr_nx;
            bus_wdata <= bus_wdata_nx;
            bus_mask  <= bus_mask_nx;
        end
    end

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq (TIMEOUT = 4); outputs sampled on the falling edge.
module tb_lsu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_fn4;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_mask;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;

    int n_chk = 0;
    int n_err = 0;

    lsu_seq #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_fn4(req_fn4), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_mask(bus_mask),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic we, input logic [3:0] fn4, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_fn4   = fn4;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Wait 'waits' BUS cycles with bus_req expected high, then present ack/err for one edge.
    task automatic bus_cycle(input int waits, input logic ack, input logic err,
                             input logic [31:0] rdata);
        for (int i = 0; i < waits; i++) begin
            chk("bus_req_wait", bus_req, 1);
            @(negedge clk);
        end
        bus_ack   = ack;
        bus_err   = err;
        bus_rdata = rdata;
        @(posedge clk);
        #1 bus_ack = 1'b0;
        bus_err = 1'b0;
        @(negedge clk);
    endtask

    // Load with ack in the first BUS cycle, then check the response and return to IDLE.
    task automatic load_chk(input string tag, input logic [3:0] fn4, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [3:0] exp_mask,
                            input logic [31:0] exp_data);
        issue(1'b0, fn4, addr, 32'd0);
        chk({tag, "_mask"}, bus_mask, exp_mask);
        bus_cycle(0, 1'b1, 1'b0, rdata);
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_err"}, rsp_err, 0);
        chk({tag, "_data"}, rsp_rdata, exp_data);
        @(negedge clk);
    endtask

    int n_hi;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_fn4 = 4'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_mask", bus_mask, 0);
        rst = 1'b0;
        @(negedge clk);

        // Signed byte load at offset 1, ack in first BUS cycle.
        issue(1'b0, 4'b1000, 32'h101, 32'd0);
        chk("lb_bus_req", bus_req, 1);
        chk("lb_addr", bus_addr, 32'h100);
        chk("lb_mask", bus_mask, 4'b0100);
        chk("lb_we", bus_we, 0);
        chk("lb_ready", req_ready, 0);
        chk("lb_no_rsp_yet", rsp_valid, 0);
        bus_cycle(0, 1'b1, 1'b0, 32'h12F45678);
        chk("lb_vld", rsp_valid, 1);
        chk("lb_err", rsp_err, 0);
        chk("lb_data", rsp_rdata, 32'hFFFFFFF4);
        chk("lb_bus_drop", bus_req, 0);
        chk("lb_ready_resp", req_ready, 0);
        @(negedge clk);
        chk("lb_vld_pulse", rsp_valid, 0);
        chk("lb_ready_back", req_ready, 1);
        chk("lb_data_hold", rsp_rdata, 32'hFFFFFFF4);

        // Half store, ack on the 4th BUS cycle (ack wins over the timeout boundary).
        issue(1'b1, 4'd1, 32'h22, 32'hAAAABEEF);
        chk("sh_we", bus_we, 1);
        chk("sh_addr", bus_addr, 32'h20);
        chk("sh_wdata", bus_wdata, 32'h0000BEEF);
        chk("sh_mask", bus_mask, 4'b0011);
        bus_cycle(3, 1'b1, 1'b0, 32'h55555555);
        chk("sh_vld", rsp_valid, 1);
        chk("sh_err", rsp_err, 0);
        chk("sh_data", rsp_rdata, 0);
        chk("sh_bus_drop", bus_req, 0);
        @(negedge clk);
        chk("sh_vld_pulse", rsp_valid, 0);

        // Byte store at offset 3.
        issue(1'b1, 4'd0, 32'h203, 32'h123456A5);
        chk("sb_wdata", bus_wdata, 32'h000000A5);
        chk("sb_mask", bus_mask, 4'b0001);
        bus_cycle(0, 1'b1, 1'b0, 32'd0);
        chk("sb_err", rsp_err, 0);
        @(negedge clk);

        load_chk("lhu", 4'd1, 32'h40, 32'h80011234, 4'b1100, 32'h00008001);
        load_chk("lh", 4'd9, 32'h40, 32'h80011234, 4'b1100, 32'hFFFF8001);
        load_chk("lh_lo", 4'd9, 32'h42, 32'h1234F00D, 4'b0011, 32'hFFFFF00D);
        load_chk("lbu", 4'd0, 32'h103, 32'h000000F4, 4'b0001, 32'h000000F4);
        load_chk("lw", 4'd2, 32'h8, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

        // Misaligned word and half: immediate error, no bus cycle.
        issue(1'b0, 4'd2, 32'h6, 32'd0);
        chk("mis_w_bus_req", bus_req, 0);
        chk("mis_w_vld", rsp_valid, 1);
        chk("mis_w_err", rsp_err, 1);
        chk("mis_w_data", rsp_rdata, 0);
        @(negedge clk);
        chk("mis_w_pulse", rsp_valid, 0);
        chk("mis_w_ready", req_ready, 1);
        issue(1'b1, 4'd1, 32'h41, 32'hFFFF);
        chk("mis_h_bus_req", bus_req, 0);
        chk("mis_h_err", rsp_err, 1);
        @(negedge clk);

        // Timeout: bus_req high for exactly TIMEOUT cycles.
        issue(1'b0, 4'd2, 32'h10, 32'd0);
        n_hi = 0;
        while (bus_req && n_hi < 20) begin
            n_hi++;
            @(negedge clk);
        end
        chk("to_cycles", n_hi, 4);
        chk("to_vld", rsp_valid, 1);
        chk("to_err", rsp_err, 1);
        chk("to_data", rsp_rdata, 0);
        @(negedge clk);

        // Simultaneous ack and err: error wins.
        issue(1'b0, 4'd2, 32'h14, 32'd0);
        bus_cycle(1, 1'b1, 1'b1, 32'h11111111);
        chk("ackerr_vld", rsp_valid, 1);
        chk("ackerr_err", rsp_err, 1);
        chk("ackerr_data", rsp_rdata, 0);
        @(negedge clk);

        // Ack while idle is ignored.
        bus_ack = 1'b1;
        @(posedge clk);
        #1 bus_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_vld", rsp_valid, 0);
        chk("idle_ack_ready", req_ready, 1);

        // Reset during BUS aborts without a response.
        issue(1'b0, 4'd2, 32'h18, 32'd0);
        @(negedge clk);
        chk("rb_bus_req", bus_req, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rb_bus_drop", bus_req, 0);
        chk("rb_no_rsp", rsp_valid, 0);
        chk("rb_ready", req_ready, 1);
        @(negedge clk);
        chk("rb_no_rsp2", rsp_valid, 0);
        load_chk("rb_lw", 4'd2, 32'h8, 32'h600DF00D, 4'b1111, 32'h600DF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
